// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg
//   Shared definitions for the pipelined ALU: the 4-bit opcode map and the
//   state encoding of the multiply sequencer.
//   Codes 0-7 keep the legacy 3-bit ALU meanings, zero-extended to 4 bits.
//   Codes E and F are reserved and reported as illegal.
package alu_pipe_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NAND = 4'h5;
    localparam logic [3:0] OP_NOTA = 4'h6;
    localparam logic [3:0] OP_PASS = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_SLT  = 4'hB;
    localparam logic [3:0] OP_SLTU = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_core
//   Purely combinational WIDTH-bit ALU covering every single-cycle opcode
//   (0-C) together with its carry/overflow/illegal flags. MUL (D) is handled
//   by the sequencer in alu_pipe, so here it simply yields zero.
// Ports
//   i_a, i_b     operands
//   i_op         4-bit opcode
//   o_result     computed result
//   o_carry      ADD/SUB carry (SUB: 1 means no borrow), else 0
//   o_overflow   signed overflow for ADD/SUB, else 0
//   o_illegal    opcode E/F
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_illegal
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;

    // Subtraction is done as A + ~B + 1 so that the carry out directly
    // reads as "no borrow" (A >= B unsigned).
    always_comb begin
        w_sum      = {1'b0, i_a} + {1'b0, i_b};
        w_diff     = {1'b0, i_a} + {1'b0, ~i_b} + (WIDTH+1)'(1);
        w_shamt    = i_b[SHW-1:0];
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        o_illegal  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result   = w_sum[WIDTH-1:0];
                o_carry    = w_sum[WIDTH];
                o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_result   = w_diff[WIDTH-1:0];
                o_carry    = w_diff[WIDTH];
                o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NAND: o_result = ~(i_a & i_b);
            OP_NOTA: o_result = ~i_a;
            OP_PASS: o_result = i_a;
            OP_SHL:  o_result = i_a << w_shamt;
            OP_SHR:  o_result = i_a >> w_shamt;
            OP_SRA:  o_result = $signed(i_a) >>> w_shamt;
            OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            OP_MUL:  o_result = '0;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe
//   Registered ALU with valid/ready handshakes on both sides. Single-cycle
//   ops land in the output register on the accept edge; MUL runs a
//   shift-add sequence (one multiplicand bit per cycle) and loads the output
//   register WIDTH+1 edges after acceptance. A held output (out_valid with
//   no out_ready) stalls the input side and keeps a finished MUL in DONE.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (A, B, opcode)
//   out_valid / out_ready output handshake (result and flags)
//   result                registered result
//   zero                  result == 0
//   carry_out             ADD/SUB carry, else 0
//   overflow              signed ADD/SUB overflow, or nonzero MUL high half
//   illegal               opcode E/F was received
//   busy                  multiply in progress
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_stateNext;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_outValid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_overflow;
    logic               r_illegal;

    logic               w_outFree;
    logic               w_accept;
    logic               w_loadAlu;
    logic               w_loadMul;
    logic [WIDTH-1:0]   w_coreResult;
    logic               w_coreCarry;
    logic               w_coreOverflow;
    logic               w_coreIllegal;
    logic [WIDTH-1:0]   w_nextResult;
    logic               w_nextCarry;
    logic               w_nextOverflow;
    logic               w_nextIllegal;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a        (A),
        .i_b        (B),
        .i_op       (opcode),
        .o_result   (w_coreResult),
        .o_carry    (w_coreCarry),
        .o_overflow (w_coreOverflow),
        .o_illegal  (w_coreIllegal)
    );

    // The output register is free when empty or being drained this cycle.
    // in_ready is gated by rst_n so nothing is offered while reset is held.
    assign w_outFree = !r_outValid || out_ready;
    assign in_ready  = rst_n && (r_state == IDLE) && w_outFree;
    assign w_accept  = in_valid && in_ready;

    // Next-state logic and the two output-register load strobes.
    always_comb begin
        w_stateNext = r_state;
        w_loadAlu   = 1'b0;
        w_loadMul   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (opcode == OP_MUL) begin
                        w_stateNext = MUL;
                    end else begin
                        w_loadAlu = 1'b1;
                    end
                end
            end
            MUL: begin
                if (r_cnt == SHW'(WIDTH-1)) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (w_outFree) begin
                    w_loadMul   = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Select what goes into the output register: the finished product
    // when leaving DONE, otherwise the combinational core result.
    always_comb begin
        if (w_loadMul) begin
            w_nextResult   = r_acc[WIDTH-1:0];
            w_nextCarry    = 1'b0;
            w_nextOverflow = |r_acc[2*WIDTH-1:WIDTH];
            w_nextIllegal  = 1'b0;
        end else begin
            w_nextResult   = w_coreResult;
            w_nextCarry    = w_coreCarry;
            w_nextOverflow = w_coreOverflow;
            w_nextIllegal  = w_coreIllegal;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Multiply datapath: operands are captured at accept so the caller may
    // change A/B afterwards; each MUL cycle adds the shifted multiplier when
    // the current multiplicand bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_mcand  <= '0;
        end else if ((r_state == IDLE) && w_accept && (opcode == OP_MUL)) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mplier <= A;
            r_mcand  <= B;
        end else if (r_state == MUL) begin
            if (r_mcand[r_cnt]) begin
                r_acc <= r_acc + ({{WIDTH{1'b0}}, r_mplier} << r_cnt);
            end
            r_cnt <= r_cnt + SHW'(1);
        end
    end

    // Output register: a new load wins over a drain, which keeps
    // back-to-back single-cycle ops at one per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_loadAlu || w_loadMul) begin
            r_outValid <= 1'b1;
            r_result   <= w_nextResult;
            r_zero     <= (w_nextResult == '0);
            r_carry    <= w_nextCarry;
            r_overflow <= w_nextOverflow;
            r_illegal  <= w_nextIllegal;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry_out = r_carry;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;
    assign busy      = (r_state == MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe
//   Self-checking bench for alu_pipe (WIDTH=32): directed vectors with
//   literal expectations, a back-pressure scenario, reset during MUL, and a
//   randomized run compared each cycle against a behavioural model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [3:0]  opCode;
    logic        outValid;
    logic        outReady;
    logic [31:0] res;
    logic        zeroF;
    logic        carryF;
    logic        ovfF;
    logic        illF;
    logic        busyF;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        carry;
        logic        ovf;
        logic        ill;
        bit          isMul;
        int          due;
    } expT;

    expT pend[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  checkEn = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .A         (opA),
        .B         (opB),
        .opcode    (opCode),
        .out_valid (outValid),
        .out_ready (outReady),
        .result    (res),
        .zero      (zeroF),
        .carry_out (carryF),
        .overflow  (ovfF),
        .illegal   (illF),
        .busy      (busyF)
    );

    // Free-running clock and edge counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural reference: what each opcode must produce, using plain
    // wide/signed arithmetic rather than any gate-level formulation.
    function automatic expT refModel(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        expT    e;
        longint s;
        logic [63:0] p;
        logic signed [31:0] sa;
        int     sh;
        sh      = int'(b[4:0]);
        sa      = a;
        e.res   = 32'd0;
        e.carry = 1'b0;
        e.ovf   = 1'b0;
        e.ill   = 1'b0;
        e.isMul = (op == 4'hD);
        e.due   = 0;
        case (op)
            4'h0: begin
                e.res   = a + b;
                e.carry = (longint'(a) + longint'(b)) >= 64'h1_0000_0000;
                s       = longint'($signed(a)) + longint'($signed(b));
                e.ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h1: begin
                e.res   = a - b;
                e.carry = (a >= b);
                s       = longint'($signed(a)) - longint'($signed(b));
                e.ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h2: e.res = a & b;
            4'h3: e.res = a | b;
            4'h4: e.res = a ^ b;
            4'h5: e.res = ~(a & b);
            4'h6: e.res = ~a;
            4'h7: e.res = a;
            4'h8: e.res = a << sh;
            4'h9: e.res = a >> sh;
            4'hA: e.res = sa >>> sh;
            4'hB: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hC: e.res = (a < b) ? 32'd1 : 32'd0;
            4'hD: begin
                p     = {32'd0, a} * {32'd0, b};
                e.res = p[31:0];
                e.ovf = (p[63:32] != 32'd0);
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Single comparison primitive: counts the check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge.
    task automatic applyStimulus(input bit v, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit ordy);
        @(negedge clk);
        inValid  = v;
        opCode   = op;
        opA      = a;
        opB      = b;
        outReady = ordy;
    endtask

    // Compare process: once inputs have settled after each falling edge,
    // check handshake, busy and payload against the model's queue, then
    // retire consumed results and enqueue newly accepted operations.
    // A single op shows its result the cycle after acceptance; a MUL shows
    // it 33 edges after the accept edge, with busy high for the first 32.
    always @(negedge clk) begin
        #1;
        if (checkEn) begin
            bit  expValid;
            bit  pending;
            bit  expReady;
            bit  expBusy;
            expT e;
            expValid = (pend.size() > 0) && (cyc >= pend[0].due);
            pending  = (pend.size() > 0) && (cyc < pend[0].due);
            expBusy  = pending && pend[0].isMul && (cyc < pend[0].due - 1);
            expReady = !pending && (!expValid || outReady);
            checkOutput("out_valid", outValid, expValid);
            checkOutput("in_ready", inReady, expReady);
            checkOutput("busy", busyF, expBusy);
            if (expValid) begin
                checkOutput("result", res, pend[0].res);
                checkOutput("zero", zeroF, pend[0].zero);
                checkOutput("carry_out", carryF, pend[0].carry);
                checkOutput("overflow", ovfF, pend[0].ovf);
                checkOutput("illegal", illF, pend[0].ill);
                if (outReady) void'(pend.pop_front());
            end
            if (inValid && expReady) begin
                e     = refModel(opCode, opA, opB);
                e.due = cyc + 1 + (e.isMul ? 33 : 0);
                pend.push_back(e);
            end
        end
    end

    // Issue one op, wait (bounded) for its result and check it against
    // literal values. expLat counts edges after the accept edge.
    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input bit eZ,
                         input bit eC, input bit eO, input bit eI, input int expLat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        applyStimulus(1, op, a, b, 1);
        for (int i = 0; i < 40 && !seen; i++) begin
            applyStimulus(0, op, a, b, 1);
            #2;
            if (outValid) begin
                seen = 1;
                lat  = i;
            end
        end
        if (!seen) begin
            checkOutput({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({name, " result"}, res, expRes);
            checkOutput({name, " zero"}, zeroF, eZ);
            checkOutput({name, " carry"}, carryF, eC);
            checkOutput({name, " ovf"}, ovfF, eO);
            checkOutput({name, " illegal"}, illF, eI);
            checkOutput({name, " latency"}, lat, expLat);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        expT m;
        logic [3:0] rop;

        rstN     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        opA      = '0;
        opB      = '0;
        opCode   = '0;

        // Reset state.
        #3;
        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset in_ready", inReady, 0);
        checkOutput("reset busy", busyF, 0);
        checkOutput("reset result", res, 0);
        checkOutput("reset zero", zeroF, 0);
        checkOutput("reset illegal", illF, 0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("post-reset in_ready", inReady, 1);
        checkEn = 1;

        // Pin the model with hand-computed values.
        m = refModel(4'h0, 32'h7FFF_FFFF, 32'd1);
        checkOutput("model add ovf", m.ovf, 1);
        m = refModel(4'h1, 32'd5, 32'd7);
        checkOutput("model sub res", m.res, 32'hFFFF_FFFE);
        m = refModel(4'hD, 32'h0001_0000, 32'h0001_0000);
        checkOutput("model mul ovf", m.ovf, 1);
        m = refModel(4'hA, 32'h8000_0000, 32'd4);
        checkOutput("model sra res", m.res, 32'hF800_0000);

        // Directed vectors with literal expectations.
        runOp("ADD 5+3",   4'h0, 32'd5, 32'd3, 32'd8, 0, 0, 0, 0, 0);
        runOp("SUB 5-7",   4'h1, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
        runOp("ADD ovf",   4'h0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 0, 1, 0, 0);
        runOp("SUB 3-3",   4'h1, 32'd3, 32'd3, 32'd0, 1, 1, 0, 0, 0);
        runOp("AND",       4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 0, 0, 0);
        runOp("OR",        4'h3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 0, 0, 0, 0, 0);
        runOp("XOR",       4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 0, 0, 0, 0, 0);
        runOp("NAND",      4'h5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF0F_FF0F, 0, 0, 0, 0, 0);
        runOp("SRA",       4'hA, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 0, 0, 0);
        runOp("SLT",       4'hB, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 0, 0);
        runOp("SLTU",      4'hC, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 0, 0, 0);
        runOp("MUL 2^32",  4'hD, 32'h0001_0000, 32'h0001_0000, 32'd0, 1, 0, 1, 0, 33);
        runOp("MUL 7*9",   4'hD, 32'd7, 32'd9, 32'd63, 0, 0, 0, 0, 33);
        runOp("ILLEGAL F", 4'hF, 32'd5, 32'd3, 32'd0, 1, 0, 0, 1, 0);

        // Back-pressure: result held for 5 cycles with the input stalled,
        // then the pending op is accepted on the release cycle.
        applyStimulus(1, 4'h0, 32'd10, 32'd20, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 4'h4, 32'h0000_00FF, 32'h0000_000F, 0);
            #2;
            checkOutput("hold in_ready", inReady, 0);
            checkOutput("hold result", res, 32'd30);
        end
        applyStimulus(1, 4'h4, 32'h0000_00FF, 32'h0000_000F, 1);
        #2;
        checkOutput("release in_ready", inReady, 1);
        applyStimulus(0, 4'h0, 32'd0, 32'd0, 1);
        #2;
        checkOutput("release next valid", outValid, 1);
        checkOutput("release next result", res, 32'h0000_00F0);

        // Reset in the middle of a multiply.
        applyStimulus(1, 4'hD, 32'd12345, 32'd678, 1);
        repeat (10) applyStimulus(0, 4'h0, 32'd0, 32'd0, 1);
        @(negedge clk);
        #3;
        rstN    = 1'b0;
        checkEn = 0;
        #1;
        checkOutput("mid-MUL reset out_valid", outValid, 0);
        checkOutput("mid-MUL reset busy", busyF, 0);
        checkOutput("mid-MUL reset in_ready", inReady, 0);
        pend.delete();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        #2;
        checkEn = 1;

        // Randomized traffic with random stalls on both sides.
        for (int n = 0; n < 1500; n++) begin
            rop = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 9) < 7, rop, pickOperand(), pickOperand(),
                          $urandom_range(0, 3) != 0);
        end

        // Drain whatever is still in flight.
        repeat (40) applyStimulus(0, 4'h0, 32'd0, 32'd0, 1);
        checkOutput("drain queue empty", pend.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
